// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one external ALU between two requesters.
// It registers the operands and the result, and returns the result on the granted response channel.
//
// state | meaning
// IDLE  | waiting for an operation; ready goes to the round-robin winner
// EXEC  | operands stable on the ALU pins; result and zero flag captured
// RESP  | result presented to the granted requester until it is taken
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= (FIRST_PRIO != 0);
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 2'b00;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    // Pointer only breaks ties; a lone requester always wins.
    assign win = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        res_d       = res_q;
        zero_d      = zero_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        rsp0_result = '0;
        rsp1_result = '0;
        rsp0_zero   = 1'b0;
        rsp1_zero   = 1'b0;

        // Handshake outputs are masked while reset is asserted so nothing is
        // accepted or delivered on the reset edge.
        case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = !win;
                    req1_ready = win;
                    grant_d    = win;
                    a_d        = win ? req1_a  : req0_a;
                    b_d        = win ? req1_b  : req0_b;
                    sel_d      = win ? req1_op : req0_op;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = (alu_result == '0);
                state_d = RESP;
            end
            RESP: begin
                if (rst_n) begin
                    if (grant_q) begin
                        rsp1_valid  = 1'b1;
                        rsp1_result = res_q;
                        rsp1_zero   = zero_q;
                        if (rsp1_ready) begin
                            ptr_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        rsp0_valid  = 1'b1;
                        rsp0_result = res_q;
                        rsp0_zero   = zero_q;
                        if (rsp0_ready) begin
                            ptr_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = sel_q;
    assign busy       = (state_q != IDLE);

endmodule
